inst_queue: RTL

Parametrised fetch-to-decode instruction queue for the pipeline front end. It replaces the single-entry hold register at the decode input with a DEPTH-entry FIFO of {pc, inst} pairs. Icache responses are absorbed while decode is stalled, and a zero pc/inst bubble is presented whenever no entry is available. The queue sits between the icache response path and the decoder/regfile read stage. Flush and branch-taken kill every queued entry in one cycle.

---
 rtl/inst_queue.sv | 84 ++++++++
 1 files changed

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO of {pc, inst} pairs.
// First-word-fall-through head; a zero pc/inst bubble is shown when empty.
// flush or br_e empties the queue in one cycle; rst has priority over both.
module inst_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int INST_W   = 32,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         br_e,
  input  logic                         in_valid,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [INST_W-1:0]            in_inst,
  output logic                         in_ready,
  output logic                         afull,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [PC_W-1:0]              out_pc,
  output logic [INST_W-1:0]            out_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = PC_W + INST_W;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] TH_C   = CW'(AFULL_TH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  head;
  logic          kill;
  logic          push;
  logic          pop;

  // Status flags depend only on registered occupancy, never on inputs.
  assign in_ready  = (count != FULL_C);
  assign out_valid = (count != '0);
  assign afull     = (count >= TH_C);

  // A kill discards any same-cycle beat and blocks the pop.
  assign kill = flush | br_e;
  assign push = in_valid & in_ready & ~kill;
  assign pop  = out_valid & out_ready & ~kill;

  // Storage array: written on accepted beats only, never cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_pc, in_inst};
    end
  end

  // Pointers and occupancy; reset outranks kill, kill outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head view: entry at rd_ptr when occupied, zero bubble otherwise.
  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head[W-1:INST_W]  : '0;
  assign out_inst = out_valid ? head[INST_W-1:0]  : '0;

endmodule
